mcu_amux_bridge: RTL

Parametrised MCU-to-fabric bridge for the STM32 FMC multiplexed (AD-muxed) NOR/PSRAM bus. It is the next generation of the FMC bus front end and sits between the MCU pins and the register/memory map of the design core. It adds:
- extended address width via extra high address pins;
- burst auto-increment;
- configurable downstream read latency;
- optional NWAIT flow control.

All pin strobes are resynchronised into `clk`; the fabric side is a single-cycle strobe bus.

---
 rtl/mcu_amux_bridge.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mcu_amux_bridge.sv
// STM32 FMC address/data-multiplexed bus front end: resynchronises the pin strobes and issues
// single-cycle rd/write strobes to the fabric. Define MCU_AMUX_NWAIT_EN to drive nwait from read readiness.
module mcu_amux_bridge #(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned RD_LAT      = 1,
   localparam int unsigned AHI_W      = (ADDR_W > 16) ? ADDR_W - 16 : 1
) (
   input  logic              clk,
   input  logic              aclr,
   input  logic              ne,
   input  logic              noe,
   input  logic              nwe,
   input  logic              nadv,
   input  logic [1:0]        nbl,
   inout  logic [15:0]       ad,
   input  logic [AHI_W-1:0]  a_hi,
   output logic              nwait,
   output logic [ADDR_W-1:0] rdaddr,
   output logic              rd,
   input  logic [15:0]       rddata,
   output logic [ADDR_W-1:0] wraddr,
   output logic [15:0]       wrdata,
   output logic [1:0]        be,
   output logic              write,
   output logic              err
);

   localparam int unsigned PIPE_W = AHI_W + 22;
   localparam logic [PIPE_W-1:0] PIPE_RST = PIPE_W'(6'h3F);

   typedef enum logic [1:0] {IDLE, ADDR, ACTIVE, RD_WAIT} state_t;

   logic [PIPE_W-1:0] sync_d [SYNC_STAGES];
   logic [PIPE_W-1:0] sync_q [SYNC_STAGES];
   logic [2:0]        prev_d, prev_q;

   state_t            state_d, state_q;
   logic [ADDR_W-1:0] ptr_d, ptr_q;
   logic [2:0]        cnt_d, cnt_q;
   logic              rd_d, rd_q;
   logic              write_d, write_q;
   logic              err_d, err_q;
   logic              errseen_d, errseen_q;
   logic [ADDR_W-1:0] rdaddr_d, rdaddr_q;
   logic [ADDR_W-1:0] wraddr_d, wraddr_q;
   logic [15:0]       wrdata_d, wrdata_q;
   logic [1:0]        be_d, be_q;
   logic [15:0]       dout_d, dout_q;

   logic              s_ne, s_noe, s_nwe, s_nadv;
   logic [1:0]        s_nbl;
   logic [15:0]       s_ad;
   logic [AHI_W-1:0]  s_ahi;
   logic              nadv_rise, nwe_rise, noe_fall, both_low, rd_done;

   // address/data/byte lanes travel with the strobes so sampled values line up with detected edges
   assign {s_ahi, s_ad, s_nbl, s_nadv, s_nwe, s_noe, s_ne} = sync_q[SYNC_STAGES-1];

   assign nadv_rise = s_nadv & ~prev_q[2];
   assign nwe_rise  = s_nwe & ~prev_q[1];
   assign noe_fall  = ~s_noe & prev_q[0];
   assign both_low  = ~s_noe & ~s_nwe;
   assign rd_done   = (state_q == RD_WAIT) && (cnt_q == 3'(RD_LAT)) && !s_ne;

   always_comb begin
      sync_d[0] = {a_hi, ad, nbl, nadv, nwe, noe, ne};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
      prev_d = {s_nadv, s_nwe, s_noe};
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      rd_d      = 1'b0;
      write_d   = 1'b0;
      err_d     = 1'b0;
      errseen_d = errseen_q & ~(s_noe & s_nwe);
      rdaddr_d  = rdaddr_q;
      wraddr_d  = wraddr_q;
      wrdata_d  = wrdata_q;
      be_d      = be_q;
      dout_d    = dout_q;
      // chip deselect abandons whatever is in flight, including a pending read capture
      if (s_ne) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: state_d = ADDR;
            ADDR: begin
               if (nadv_rise) begin
                  ptr_d   = ADDR_W'({s_ahi, s_ad});
                  state_d = ACTIVE;
               end
            end
            ACTIVE: begin
               if (!s_nadv) begin
                  state_d = ADDR;
               end else if (both_low) begin
                  err_d     = ~errseen_q;
                  errseen_d = 1'b1;
               end else if (!errseen_q && nwe_rise) begin
                  if (s_nbl != 2'b11) begin
                     write_d  = 1'b1;
                     wraddr_d = ptr_q;
                     wrdata_d = s_ad;
                     be_d     = ~s_nbl;
                  end
                  ptr_d = ptr_q + ADDR_W'(1);
               end else if (!errseen_q && noe_fall) begin
                  rd_d     = 1'b1;
                  rdaddr_d = ptr_q;
                  cnt_d    = '0;
                  state_d  = RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (rd_done) begin
                  dout_d  = rddata;
                  ptr_d   = ptr_q + ADDR_W'(1);
                  state_d = ACTIVE;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         sync_q    <= '{default: PIPE_RST};
         prev_q    <= '1;
         state_q   <= IDLE;
         ptr_q     <= '0;
         cnt_q     <= '0;
         rd_q      <= 1'b0;
         write_q   <= 1'b0;
         err_q     <= 1'b0;
         errseen_q <= 1'b0;
         rdaddr_q  <= '0;
         wraddr_q  <= '0;
         wrdata_q  <= '0;
         be_q      <= '0;
         dout_q    <= '0;
      end else begin
         sync_q    <= sync_d;
         prev_q    <= prev_d;
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         rd_q      <= rd_d;
         write_q   <= write_d;
         err_q     <= err_d;
         errseen_q <= errseen_d;
         rdaddr_q  <= rdaddr_d;
         wraddr_q  <= wraddr_d;
         wrdata_q  <= wrdata_d;
         be_q      <= be_d;
         dout_q    <= dout_d;
      end
   end

`ifdef MCU_AMUX_NWAIT_EN
   logic data_ok_d, data_ok_q;

   always_comb begin
      data_ok_d = rd_done | (data_ok_q & ~s_noe & ~s_ne);
   end

   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) data_ok_q <= 1'b0;
      else       data_ok_q <= data_ok_d;
   end

   // raw pins so wait asserts without synchroniser delay; reset releases it immediately
   assign nwait = ~(aclr & ~ne & ~noe & ~data_ok_q);
`else
   assign nwait = 1'b1;
`endif

   assign ad     = (aclr && !ne && !noe && nadv) ? dout_q : 'z;
   assign rdaddr = rdaddr_q;
   assign rd     = rd_q;
   assign wraddr = wraddr_q;
   assign wrdata = wrdata_q;
   assign be     = be_q;
   assign write  = write_q;
   assign err    = err_q;

endmodule
